// File: rtl/led_pattern_sequencer.sv
// rtl/led_pattern_sequencer.sv - step timing and mode control for the 8-LED running light
module led_pattern_sequencer #(
    parameter int TICK_DIV = 100000,
    parameter int DWELL_MS = 2000,
    parameter int AUTO_ADV = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       next_pulse,
    input  logic       pause_pulse,
    input  logic [2:0] speed_sel,
    output logic [7:0] led,
    output logic [1:0] mode,
    output logic       paused,
    output logic       step_tick
);

    typedef enum logic [1:0] {
        M_LEFT   = 2'd0,
        M_RIGHT  = 2'd1,
        M_BOUNCE = 2'd2,
        M_BLINK  = 2'd3
    } mode_t;

    localparam logic [31:0] PRE_MAX   = 32'(TICK_DIV - 1);
    localparam logic [31:0] DWELL_MAX = 32'(DWELL_MS - 1);

    mode_t       state;
    mode_t       state_next;
    logic [31:0] pre_cnt;
    logic [9:0]  step_cnt;
    logic [31:0] dwell_cnt;
    logic        dir_up;
    logic        en_q;

    logic        run;
    logic        ms_tick;
    logic [9:0]  period;
    logic        step_due;
    logic        dwell_due;
    logic        advance;
    logic        reload;
    logic [7:0]  led_step;
    logic        dir_step;

    function automatic logic [9:0] step_period(input logic [2:0] sel);
        case (sel)
            3'd0:    step_period = 10'd10;
            3'd1:    step_period = 10'd20;
            3'd2:    step_period = 10'd40;
            3'd3:    step_period = 10'd100;
            3'd4:    step_period = 10'd200;
            default: step_period = 10'd500;
        endcase
    endfunction

    function automatic logic [7:0] entry_pattern(input mode_t m);
        case (m)
            M_LEFT:   entry_pattern = 8'h01;
            M_RIGHT:  entry_pattern = 8'h80;
            M_BOUNCE: entry_pattern = 8'h01;
            default:  entry_pattern = 8'hFF;
        endcase
    endfunction

    // Event decode: timers only run while enabled and not paused; a pending
    // advance always takes priority over a step falling on the same cycle.
    always_comb begin
        run       = en && !paused;
        ms_tick   = run && (pre_cnt == PRE_MAX);
        period    = step_period(speed_sel);
        step_due  = ms_tick && (step_cnt >= period - 10'd1);
        dwell_due = (AUTO_ADV != 0) && ms_tick && (dwell_cnt >= DWELL_MAX);
        advance   = en && (next_pulse || dwell_due);
        reload    = en && !en_q;
    end

    // Next LED pattern for one step in the current mode.
    always_comb begin
        led_step = led;
        dir_step = dir_up;
        case (state)
            M_LEFT:  led_step = {led[6:0], led[7]};
            M_RIGHT: led_step = {led[0], led[7:1]};
            M_BOUNCE: begin
                if (led == 8'h80) begin
                    led_step = 8'h40;
                    dir_step = 1'b0;
                end else if (led == 8'h01) begin
                    led_step = 8'h02;
                    dir_step = 1'b1;
                end else if (dir_up) begin
                    led_step = led << 1;
                end else begin
                    led_step = led >> 1;
                end
            end
            default: led_step = ~led;
        endcase
    end

    // Mode FSM next state: wraps LEFT -> RIGHT -> BOUNCE -> BLINK -> LEFT.
    always_comb begin
        state_next = state;
        if (advance) begin
            state_next = mode_t'(state + 2'd1);
        end
    end

    // Mode register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= M_LEFT;
        end else begin
            state <= state_next;
        end
    end

    // Prescaler, step and dwell timers; all cleared on disable or advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt   <= '0;
            step_cnt  <= '0;
            dwell_cnt <= '0;
        end else if (!en || advance || reload) begin
            pre_cnt   <= '0;
            step_cnt  <= '0;
            dwell_cnt <= '0;
        end else if (run) begin
            pre_cnt <= ms_tick ? 32'd0 : pre_cnt + 32'd1;
            if (ms_tick) begin
                step_cnt <= step_due ? 10'd0 : step_cnt + 10'd1;
                if (dwell_cnt < DWELL_MAX) begin
                    dwell_cnt <= dwell_cnt + 32'd1;
                end
            end
        end
    end

    // LED pattern, bounce direction, pause flag and step strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led       <= 8'h01;
            dir_up    <= 1'b1;
            paused    <= 1'b0;
            step_tick <= 1'b0;
            en_q      <= 1'b1;
        end else begin
            en_q      <= en;
            step_tick <= 1'b0;
            if (!en) begin
                led <= 8'h00;
            end else begin
                if (pause_pulse) begin
                    paused <= ~paused;
                end
                if (advance) begin
                    led    <= entry_pattern(state_next);
                    dir_up <= 1'b1;
                end else if (reload) begin
                    led    <= entry_pattern(state);
                    dir_up <= 1'b1;
                end else if (step_due) begin
                    led       <= led_step;
                    dir_up    <= dir_step;
                    step_tick <= 1'b1;
                end
            end
        end
    end

    assign mode = state;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// tb/tb_led_pattern_sequencer.sv - directed self-checking bench for led_pattern_sequencer
module tb_led_pattern_sequencer;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       next_pulse;
    logic       pause_pulse;
    logic [2:0] speed_sel;

    logic [7:0] m_led;
    logic [1:0] m_mode;
    logic       m_paused;
    logic       m_step_tick;
    logic [7:0] a_led;
    logic [1:0] a_mode;
    logic       a_paused;
    logic       a_step_tick;

    int checks = 0;
    int errors = 0;

    led_pattern_sequencer #(.TICK_DIV(4), .DWELL_MS(20), .AUTO_ADV(0)) dut_man (
        .clk(clk), .rst_n(rst_n), .en(en), .next_pulse(next_pulse),
        .pause_pulse(pause_pulse), .speed_sel(speed_sel),
        .led(m_led), .mode(m_mode), .paused(m_paused), .step_tick(m_step_tick)
    );

    led_pattern_sequencer #(.TICK_DIV(4), .DWELL_MS(20), .AUTO_ADV(1)) dut_auto (
        .clk(clk), .rst_n(rst_n), .en(en), .next_pulse(next_pulse),
        .pause_pulse(pause_pulse), .speed_sel(speed_sel),
        .led(a_led), .mode(a_mode), .paused(a_paused), .step_tick(a_step_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       nxt;
        logic       pse;
        logic       en_lvl;
        logic [1:0] mode;
        logic [7:0] led;
        logic       paused;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic wait_step(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!m_step_tick && n < 5000);
        if (!m_step_tick) check("step_timeout", 32'd0, 32'd1);
    endtask

    // Reference step for the manual instance: returns {dir_up, led}.
    function automatic logic [8:0] model_step(input logic [1:0] md, input logic [7:0] l, input logic d);
        case (md)
            2'd0: return {d, l[6:0], l[7]};
            2'd1: return {d, l[0], l[7:1]};
            2'd2: begin
                if (l == 8'h80) return {1'b0, 8'h40};
                if (l == 8'h01) return {1'b1, 8'h02};
                return d ? {d, l << 1} : {d, l >> 1};
            end
            default: return {d, ~l};
        endcase
    endfunction

    initial begin
        int         n;
        logic [7:0] exp_led;
        logic       exp_dir;
        logic [8:0] nxt;
        logic [7:0] frozen_led;
        int         ticks_seen;
        int         led_changes;

        vecs[0]  = '{1'b1, 1'b0, 1'b1, 2'd1, 8'h80, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 1'b1, 2'd2, 8'h01, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 1'b1, 2'd3, 8'hFF, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 1'b1, 2'd0, 8'h01, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 1'b1, 2'd0, 8'h01, 1'b1};
        vecs[5]  = '{1'b1, 1'b0, 1'b1, 2'd1, 8'h80, 1'b1};
        vecs[6]  = '{1'b0, 1'b1, 1'b1, 2'd1, 8'h80, 1'b0};
        vecs[7]  = '{1'b1, 1'b1, 1'b1, 2'd2, 8'h01, 1'b1};
        vecs[8]  = '{1'b0, 1'b1, 1'b1, 2'd2, 8'h01, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 2'd2, 8'h00, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 2'd2, 8'h00, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 2'd2, 8'h00, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 1'b1, 2'd2, 8'h01, 1'b0};

        rst_n = 1'b0; en = 1'b1; next_pulse = 1'b0; pause_pulse = 1'b0; speed_sel = 3'd0;
        repeat (3) @(negedge clk);
        check("rst_led", m_led, 8'h01);
        check("rst_mode", m_mode, 2'd0);
        check("rst_paused", m_paused, 1'b0);
        check("rst_step_tick", m_step_tick, 1'b0);

        // Free-running LEFT at 10 ms steps: one step every 40 clocks.
        rst_n = 1'b1;
        exp_led = 8'h01;
        for (int i = 0; i < 8; i++) begin
            wait_step(n);
            check("left_interval", n, 40);
            exp_led = {exp_led[6:0], exp_led[7]};
            check("left_led", m_led, exp_led);
        end

        // Mode advance, pause and enable vectors.
        for (int i = 0; i < 13; i++) begin
            next_pulse  = vecs[i].nxt;
            pause_pulse = vecs[i].pse;
            en          = vecs[i].en_lvl;
            @(negedge clk);
            next_pulse  = 1'b0;
            pause_pulse = 1'b0;
            check($sformatf("vec%0d_mode", i), m_mode, vecs[i].mode);
            check($sformatf("vec%0d_led", i), m_led, vecs[i].led);
            check($sformatf("vec%0d_paused", i), m_paused, vecs[i].paused);
            repeat (9) @(negedge clk);
        end

        // BOUNCE free-run across both reversal points.
        exp_led = 8'h01;
        exp_dir = 1'b1;
        for (int i = 0; i < 15; i++) begin
            wait_step(n);
            nxt = model_step(2'd2, exp_led, exp_dir);
            exp_dir = nxt[8];
            exp_led = nxt[7:0];
            check("bounce_led", m_led, exp_led);
        end

        // Step period selection, including clamping of out-of-range index.
        speed_sel = 3'd1;
        for (int i = 0; i < 2; i++) begin
            wait_step(n);
            nxt = model_step(2'd2, exp_led, exp_dir);
            exp_dir = nxt[8];
            exp_led = nxt[7:0];
            check("speed1_led", m_led, exp_led);
        end
        check("speed1_interval", n, 80);
        speed_sel = 3'd7;
        for (int i = 0; i < 2; i++) begin
            wait_step(n);
            nxt = model_step(2'd2, exp_led, exp_dir);
            exp_dir = nxt[8];
            exp_led = nxt[7:0];
        end
        check("speed7_interval", n, 2000);
        check("speed7_led", m_led, exp_led);
        speed_sel = 3'd0;
        wait_step(n);
        nxt = model_step(2'd2, exp_led, exp_dir);
        exp_dir = nxt[8];
        exp_led = nxt[7:0];

        // Pause freezes stepping; second pause resumes from the frozen state.
        pause_pulse = 1'b1;
        @(negedge clk);
        pause_pulse = 1'b0;
        check("pause_set", m_paused, 1'b1);
        frozen_led = m_led;
        ticks_seen = 0;
        led_changes = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (m_step_tick) ticks_seen++;
            if (m_led !== frozen_led) led_changes++;
        end
        check("pause_no_ticks", ticks_seen, 0);
        check("pause_led_frozen", led_changes, 0);
        check("pause_led_value", m_led, exp_led);
        check("pause_mode", m_mode, 2'd2);
        pause_pulse = 1'b1;
        @(negedge clk);
        pause_pulse = 1'b0;
        check("pause_clear", m_paused, 1'b0);
        wait_step(n);
        nxt = model_step(2'd2, exp_led, exp_dir);
        check("resume_led", m_led, nxt[7:0]);

        // Auto-advance on dwell expiry, and a coincident next_pulse.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (79) @(negedge clk);
        check("auto_pre_mode", a_mode, 2'd0);
        check("auto_pre_led", a_led, 8'h02);
        @(negedge clk);
        check("auto_mode", a_mode, 2'd1);
        check("auto_led", a_led, 8'h80);
        check("auto_no_step", a_step_tick, 1'b0);
        repeat (79) @(negedge clk);
        check("auto2_pre_mode", a_mode, 2'd1);
        next_pulse = 1'b1;
        @(negedge clk);
        next_pulse = 1'b0;
        check("auto_coincide_mode", a_mode, 2'd2);
        check("auto_coincide_led", a_led, 8'h01);
        repeat (5) @(negedge clk);
        check("auto_single_adv", a_mode, 2'd2);

        // Asynchronous reset mid-run takes effect without a clock edge.
        check("pre_reset_mode", m_mode, 2'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_mode_m", m_mode, 2'd0);
        check("async_rst_led_m", m_led, 8'h01);
        check("async_rst_mode_a", a_mode, 2'd0);
        check("async_rst_led_a", a_led, 8'h01);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
